// File: rtl/blink_conditioner.sv
// blink_conditioner: synchronizes and glitch-filters the raw blink input, then
// produces rise/fall pulses, a rising-edge-to-rising-edge period measurement
// and a loss-of-signal flag for the downstream decision counter.
module blink_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int PERIOD_W       = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blinkyRaw,
    output logic                blinkyClean,
    output logic                risePulse,
    output logic                fallPulse,
    output logic [PERIOD_W-1:0] periodCycles,
    output logic                periodValid,
    output logic                lostSignal
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int LW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0]       FILT_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [LW-1:0]       LOST_MAX   = LW'(TIMEOUT_CYCLES);
    // lostSignal must be set on the edge where lost_cnt reaches LOST_MAX,
    // so the decision is taken while lost_cnt still holds LOST_MAX-1.
    localparam logic [LW-1:0]       LOST_ARM   = LW'(TIMEOUT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncd;
    logic [FW-1:0]          filter_cnt;
    logic                   qual_rise;
    logic [PERIOD_W-1:0]    period_cnt;
    logic [PERIOD_W-1:0]    period_next;
    logic [LW-1:0]          lost_cnt;
    logic                   have_ref;

    assign syncd       = sync_q[SYNC_STAGES-1];
    assign qual_rise   = syncd && !blinkyClean && (filter_cnt == FILT_LAST);
    assign period_next = (period_cnt == PERIOD_MAX) ? PERIOD_MAX
                                                    : period_cnt + PERIOD_W'(1);

    // Plain shift-register synchronizer; nothing between the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], blinkyRaw};
        end
    end

    // Persistence filter: clean level only follows syncd after it has differed
    // for FILTER_CYCLES consecutive cycles; edge pulses fire on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            filter_cnt  <= '0;
            blinkyClean <= 1'b0;
            risePulse   <= 1'b0;
            fallPulse   <= 1'b0;
        end else begin
            risePulse <= 1'b0;
            fallPulse <= 1'b0;
            if (syncd == blinkyClean) begin
                filter_cnt <= '0;
            end else if (filter_cnt == FILT_LAST) begin
                filter_cnt  <= '0;
                blinkyClean <= syncd;
                risePulse   <= syncd;
                fallPulse   <= !syncd;
            end else begin
                filter_cnt <= filter_cnt + FW'(1);
            end
        end
    end

    // Saturating rise-to-rise period counter; only reports once a reference
    // rise has been seen since reset or the last timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt   <= '0;
            periodCycles <= '0;
            periodValid  <= 1'b0;
        end else begin
            periodValid <= 1'b0;
            if (qual_rise) begin
                period_cnt <= '0;
                if (have_ref) begin
                    periodCycles <= period_next;
                    periodValid  <= 1'b1;
                end
            end else begin
                period_cnt <= period_next;
            end
        end
    end

    // Loss-of-signal timer; a rising edge always beats a coinciding expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt   <= '0;
            lostSignal <= 1'b1;
            have_ref   <= 1'b0;
        end else if (qual_rise) begin
            lost_cnt   <= '0;
            lostSignal <= 1'b0;
            have_ref   <= 1'b1;
        end else begin
            if (lost_cnt != LOST_MAX) begin
                lost_cnt <= lost_cnt + LW'(1);
            end
            if (lost_cnt >= LOST_ARM) begin
                lostSignal <= 1'b1;
                have_ref   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_conditioner.sv
// Bench for blink_conditioner: stimulus tasks push expected event cycle stamps
// into queues; a negedge monitor logs observed events; tasks pop and compare.
module tb_blink_conditioner;

    localparam int FILT = 4;
    localparam int SYNC = 2;
    localparam int TMO  = 100;
    localparam int LAT  = SYNC + FILT;

    typedef struct {
        int t;
        int v;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blinkyRaw = 1'b0;

    logic       blinkyClean, risePulse, fallPulse, periodValid, lostSignal;
    logic [7:0] periodCycles;
    logic       clean6, rise6, fall6, valid6, lost6;
    logic [5:0] period6;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic prev_lost = 1'b1;

    int  obs_rise[$], obs_fall[$], obs_lset[$], obs_lclr[$];
    int  exp_rise[$], exp_fall[$], exp_lset[$], exp_lclr[$];
    ev_t obs_val[$], obs_val6[$], exp_val[$], exp_val6[$];

    blink_conditioner #(
        .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO), .PERIOD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .blinkyRaw(blinkyRaw), .blinkyClean(blinkyClean),
        .risePulse(risePulse), .fallPulse(fallPulse), .periodCycles(periodCycles),
        .periodValid(periodValid), .lostSignal(lostSignal)
    );

    blink_conditioner #(
        .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO), .PERIOD_W(6)
    ) dut6 (
        .clk(clk), .rst(rst), .blinkyRaw(blinkyRaw), .blinkyClean(clean6),
        .risePulse(rise6), .fallPulse(fall6), .periodCycles(period6),
        .periodValid(valid6), .lostSignal(lost6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        ev_t e;
        if (risePulse) obs_rise.push_back(cyc);
        if (fallPulse) obs_fall.push_back(cyc);
        if (periodValid) begin
            e.t = cyc; e.v = int'(periodCycles);
            obs_val.push_back(e);
        end
        if (valid6) begin
            e.t = cyc; e.v = int'(period6);
            obs_val6.push_back(e);
        end
        if (lostSignal && !prev_lost) obs_lset.push_back(cyc);
        if (!lostSignal && prev_lost) obs_lclr.push_back(cyc);
        prev_lost = lostSignal;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        obs_rise.delete(); obs_fall.delete(); obs_lset.delete(); obs_lclr.delete();
        exp_rise.delete(); exp_fall.delete(); exp_lset.delete(); exp_lclr.delete();
        obs_val.delete(); obs_val6.delete(); exp_val.delete(); exp_val6.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blinkyRaw = 1'b0;
        step(2);
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_tests++;
        if ({blinkyClean, risePulse, fallPulse, periodValid, lostSignal, periodCycles} !== {5'b00001, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values got clean=%b rise=%b fall=%b valid=%b lost=%b period=%0d exp 0 0 0 0 1 0",
                     blinkyClean, risePulse, fallPulse, periodValid, lostSignal, periodCycles);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            step(1);
            n_tests++;
            if ({blinkyClean, risePulse, fallPulse, periodValid, lostSignal,
                 clean6, rise6, fall6, valid6, lost6} !== 10'b00001_00001) begin
                n_fail++;
                if (bad < 5) $display("FAIL const_low cycle %0d got %b %b exp 00001 00001", i,
                    {blinkyClean, risePulse, fallPulse, periodValid, lostSignal},
                    {clean6, rise6, fall6, valid6, lost6});
                bad++;
            end
        end
    endtask

    task automatic test_first_rise();
        int c;
        do_reset();
        step(3);
        c = cyc;
        blinkyRaw = 1'b1;
        step(LAT - 1);
        n_tests++;
        if ({blinkyClean, lostSignal} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_rise_early got clean=%b lost=%b at +%0d exp clean=0 lost=1",
                     blinkyClean, lostSignal, cyc - c);
        end
        step(1);
        n_tests++;
        if ({blinkyClean, risePulse, lostSignal, periodValid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL first_rise_edge got clean=%b rise=%b lost=%b valid=%b at +%0d exp 1 1 0 0",
                     blinkyClean, risePulse, lostSignal, periodValid, cyc - c);
        end
        step(1);
        n_tests++;
        if ({blinkyClean, risePulse, lostSignal} !== 3'b100) begin
            n_fail++;
            $display("FAIL first_rise_oneshot got clean=%b rise=%b lost=%b exp 1 0 0",
                     blinkyClean, risePulse, lostSignal);
        end
        step(20);
        n_tests++;
        if (obs_val.size() !== 0) begin
            n_fail++;
            $display("FAIL first_rise_noperiod got %0d strobes exp 0", obs_val.size());
        end
    endtask

    task automatic test_square(input string name, input int hi, input int lo, input int nper);
        int p, c, r, prev_r, o, e;
        ev_t oe, ee;
        p = hi + lo;
        prev_r = 0;
        do_reset();
        step(2);
        for (int k = 0; k < nper; k++) begin
            c = cyc;
            blinkyRaw = 1'b1;
            r = c + LAT;
            exp_rise.push_back(r);
            if (k > 0 && p > TMO) exp_lset.push_back(prev_r + TMO);
            if (k == 0 || p > TMO) exp_lclr.push_back(r);
            if (k > 0 && p < TMO) begin
                ee.t = r; ee.v = (p > 255) ? 255 : p;
                exp_val.push_back(ee);
                ee.v = (p > 63) ? 63 : p;
                exp_val6.push_back(ee);
            end
            step(hi);
            exp_fall.push_back(cyc + LAT);
            blinkyRaw = 1'b0;
            step(lo);
            prev_r = r;
        end
        exp_lset.push_back(prev_r + TMO);
        step(TMO + 20);

        n_tests++;
        if (obs_rise.size() !== exp_rise.size()) begin
            n_fail++; $display("FAIL %s rise_count got %0d exp %0d", name, obs_rise.size(), exp_rise.size());
        end
        while (obs_rise.size() > 0 && exp_rise.size() > 0) begin
            o = obs_rise.pop_front(); e = exp_rise.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL %s rise_cycle got %0d exp %0d", name, o, e); end
        end
        n_tests++;
        if (obs_fall.size() !== exp_fall.size()) begin
            n_fail++; $display("FAIL %s fall_count got %0d exp %0d", name, obs_fall.size(), exp_fall.size());
        end
        while (obs_fall.size() > 0 && exp_fall.size() > 0) begin
            o = obs_fall.pop_front(); e = exp_fall.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL %s fall_cycle got %0d exp %0d", name, o, e); end
        end
        n_tests++;
        if (obs_lset.size() !== exp_lset.size()) begin
            n_fail++; $display("FAIL %s lost_set_count got %0d exp %0d", name, obs_lset.size(), exp_lset.size());
        end
        while (obs_lset.size() > 0 && exp_lset.size() > 0) begin
            o = obs_lset.pop_front(); e = exp_lset.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL %s lost_set_cycle got %0d exp %0d", name, o, e); end
        end
        n_tests++;
        if (obs_lclr.size() !== exp_lclr.size()) begin
            n_fail++; $display("FAIL %s lost_clr_count got %0d exp %0d", name, obs_lclr.size(), exp_lclr.size());
        end
        while (obs_lclr.size() > 0 && exp_lclr.size() > 0) begin
            o = obs_lclr.pop_front(); e = exp_lclr.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL %s lost_clr_cycle got %0d exp %0d", name, o, e); end
        end
        n_tests++;
        if (obs_val.size() !== exp_val.size()) begin
            n_fail++; $display("FAIL %s valid_count got %0d exp %0d", name, obs_val.size(), exp_val.size());
        end
        while (obs_val.size() > 0 && exp_val.size() > 0) begin
            oe = obs_val.pop_front(); ee = exp_val.pop_front(); n_tests++;
            if (oe.t !== ee.t || oe.v !== ee.v) begin
                n_fail++; $display("FAIL %s period got %0d@%0d exp %0d@%0d", name, oe.v, oe.t, ee.v, ee.t);
            end
        end
        n_tests++;
        if (obs_val6.size() !== exp_val6.size()) begin
            n_fail++; $display("FAIL %s valid6_count got %0d exp %0d", name, obs_val6.size(), exp_val6.size());
        end
        while (obs_val6.size() > 0 && exp_val6.size() > 0) begin
            oe = obs_val6.pop_front(); ee = exp_val6.pop_front(); n_tests++;
            if (oe.t !== ee.t || oe.v !== ee.v) begin
                n_fail++; $display("FAIL %s period6 got %0d@%0d exp %0d@%0d", name, oe.v, oe.t, ee.v, ee.t);
            end
        end
    endtask

    task automatic test_glitch();
        int c, o;
        do_reset();
        step(2);
        for (int w = 1; w < FILT; w++) begin
            blinkyRaw = 1'b1;
            step(w);
            blinkyRaw = 1'b0;
            step(12);
        end
        n_tests++;
        if (blinkyClean !== 1'b0 || obs_rise.size() !== 0 || obs_fall.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_reject got clean=%b rises=%0d falls=%0d exp 0 0 0",
                     blinkyClean, obs_rise.size(), obs_fall.size());
        end
        c = cyc;
        blinkyRaw = 1'b1;
        exp_rise.push_back(c + LAT);
        step(FILT);
        exp_fall.push_back(cyc + LAT);
        blinkyRaw = 1'b0;
        step(15);
        n_tests++;
        if (obs_rise.size() !== 1 || obs_fall.size() !== 1) begin
            n_fail++;
            $display("FAIL glitch_min_pulse_count got rises=%0d falls=%0d exp 1 1",
                     obs_rise.size(), obs_fall.size());
        end
        while (obs_rise.size() > 0 && exp_rise.size() > 0) begin
            o = obs_rise.pop_front(); n_tests++;
            if (o !== exp_rise[0]) begin n_fail++; $display("FAIL glitch_rise_cycle got %0d exp %0d", o, exp_rise[0]); end
            void'(exp_rise.pop_front());
        end
        while (obs_fall.size() > 0 && exp_fall.size() > 0) begin
            o = obs_fall.pop_front(); n_tests++;
            if (o !== exp_fall[0]) begin n_fail++; $display("FAIL glitch_fall_cycle got %0d exp %0d", o, exp_fall[0]); end
            void'(exp_fall.pop_front());
        end
    endtask

    task automatic test_reset_midop();
        int c, c2, o;
        ev_t oe;
        do_reset();
        step(2);
        for (int k = 0; k < 2; k++) begin
            blinkyRaw = 1'b1; step(20);
            blinkyRaw = 1'b0; step(20);
        end
        blinkyRaw = 1'b1;
        step(15);
        n_tests++;
        if ({blinkyClean, lostSignal, periodCycles} !== {2'b10, 8'd40}) begin
            n_fail++;
            $display("FAIL midop_before got clean=%b lost=%b period=%0d exp 1 0 40",
                     blinkyClean, lostSignal, periodCycles);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_tests++;
        if ({blinkyClean, risePulse, fallPulse, periodValid, lostSignal, periodCycles} !== {5'b00001, 8'd0}) begin
            n_fail++;
            $display("FAIL midop_reset got clean=%b rise=%b fall=%b valid=%b lost=%b period=%0d exp 0 0 0 0 1 0",
                     blinkyClean, risePulse, fallPulse, periodValid, lostSignal, periodCycles);
        end
        clear_queues();
        c = cyc;
        exp_rise.push_back(c + LAT);
        step(20);
        blinkyRaw = 1'b0;
        step(20);
        c2 = cyc;
        blinkyRaw = 1'b1;
        exp_rise.push_back(c2 + LAT);
        step(12);
        n_tests++;
        if (obs_rise.size() !== 2) begin
            n_fail++; $display("FAIL midop_rise_count got %0d exp 2", obs_rise.size());
        end
        while (obs_rise.size() > 0 && exp_rise.size() > 0) begin
            o = obs_rise.pop_front(); n_tests++;
            if (o !== exp_rise[0]) begin n_fail++; $display("FAIL midop_rise_cycle got %0d exp %0d", o, exp_rise[0]); end
            void'(exp_rise.pop_front());
        end
        n_tests++;
        if (obs_val.size() !== 1) begin
            n_fail++; $display("FAIL midop_valid_count got %0d exp 1", obs_val.size());
        end
        if (obs_val.size() > 0) begin
            oe = obs_val.pop_front(); n_tests++;
            if (oe.t !== c2 + LAT || oe.v !== c2 - c) begin
                n_fail++; $display("FAIL midop_period got %0d@%0d exp %0d@%0d", oe.v, oe.t, c2 - c, c2 + LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_rise();
        test_square("sq20", 20, 20, 4);
        test_glitch();
        test_square("sq300", 150, 150, 3);
        test_square("sq90", 45, 45, 3);
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_conditioner.md
Name: blink_conditioner

Overview:
- Front-end stage that sits directly upstream of the blink-frequency decision counter.
- Takes the raw, asynchronous photodetector/LED "blinky" level and synchronizes and glitch-filters it.
- Emits single-cycle rise and fall pulses plus a measured rising-edge-to-rising-edge period in clk cycles.
- Flags loss of signal so the decision stage can discard stale data. 100 MHz clk assumed for defaults.

Parameters:
- SYNC_STAGES, 2: flip-flops in the input synchronizer chain; legal values 2 or more.
- FILTER_CYCLES, 1000: cycles the synchronized level must differ from the clean level before the clean level toggles (10 us at 100 MHz); legal values 1 or more.
- TIMEOUT_CYCLES, 10000000: cycles without a qualified rising edge before lostSignal asserts (100 ms).
- PERIOD_W, 24: width of the period measurement counter.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- blinkyRaw, input, 1: asynchronous raw blink input.
- blinkyClean, output, 1: synchronized, filtered level.
- risePulse, output, 1: one-cycle pulse on each qualified 0->1 of blinkyClean.
- fallPulse, output, 1: one-cycle pulse on each qualified 1->0 of blinkyClean.
- periodCycles, output, PERIOD_W: clk cycles between the last two qualified rising edges.
- periodValid, output, 1: one-cycle strobe; periodCycles updated this cycle.
- lostSignal, output, 1: no qualified rising edge within TIMEOUT_CYCLES.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Clears the sync chain, filter counter and period counter to 0.
  - Clears the first-edge flag ("haveRef").
  - Outputs: blinkyClean=0, risePulse=0, fallPulse=0, periodCycles=0, periodValid=0, lostSignal=1.
  - Reset mid-operation discards any partial filter count and period count; the next rising edge is treated as the first.
- Synchronizer: a plain SYNC_STAGES-deep shift chain. "syncd" is the last stage. No logic is placed between stages.
- Filter:
  - If syncd == blinkyClean, filterCnt is set to 0.
  - Otherwise filterCnt increments each cycle.
  - When filterCnt == FILTER_CYCLES-1 and syncd still differs, blinkyClean takes syncd on that edge and filterCnt is set to 0.
  - A glitch shorter than FILTER_CYCLES cycles never reaches blinkyClean.
- Latency: a clean step held on blinkyRaw appears on blinkyClean exactly SYNC_STAGES+FILTER_CYCLES clk edges after the first edge that samples the new level.
- Edge pulses:
  - risePulse and fallPulse are registered and assert on the same edge that blinkyClean changes. They are high for exactly one cycle.
  - They are never both high in the same cycle.
- Period measurement:
  - periodCnt increments every cycle and saturates at 2^PERIOD_W-1 (no wrap).
  - On a qualified rising edge with haveRef=1: periodCycles <= periodCnt+1 (saturated), periodValid=1 for one cycle, periodCnt <= 0.
  - On a qualified rising edge with haveRef=0: no periodValid, periodCnt <= 0, haveRef <= 1.
  - periodCycles holds its value between strobes.
- Timeout:
  - lostCnt counts cycles since the last qualified rising edge and saturates at TIMEOUT_CYCLES.
  - When lostCnt reaches TIMEOUT_CYCLES: lostSignal <= 1 and haveRef <= 0. The next rising edge gives no period; the stale reference is discarded.
  - On a qualified rising edge: lostCnt <= 0 and lostSignal <= 0 on the same edge that risePulse asserts.
  - If timeout expiry and a rising edge coincide, the rising edge wins: lostSignal=0, and haveRef follows the normal rising-edge rule.
- Constant input: blinkyClean stays at its last level, no pulses are generated, and lostSignal asserts after TIMEOUT_CYCLES.

Test Plan:
- Bench parameters for all scenarios: FILTER_CYCLES=4, SYNC_STAGES=2, TIMEOUT_CYCLES=100, PERIOD_W=8.
- Reset, then blinkyRaw=0 for 120 cycles -> blinkyClean=0, no pulses, lostSignal=1 throughout, periodValid never asserts.
- blinkyRaw 0->1 held -> blinkyClean rises exactly 6 edges after the first edge sampling 1; risePulse high 1 cycle; lostSignal drops on that same edge; no periodValid (first edge).
- Square wave with 20 cycles high and 20 cycles low -> after the first rise, periodValid pulses every 40 cycles with periodCycles=40; fallPulse occurs 20 cycles after each risePulse.
- 3-cycle high glitches on a low input -> blinkyClean stays 0, no risePulse; a 4-cycle pulse does propagate.
- Square wave with 300-cycle period -> lostSignal asserts 100 cycles after each rise and clears on the next risePulse; periodValid never fires (reference discarded). Repeat with period 90 and PERIOD_W=6 -> periodCycles saturates at 63.
- Assert rst for 1 cycle mid-way through a high phase -> all outputs return to reset values on that edge, and the next rise gives no periodValid.
